// File: rtl/hw_accel_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hw_accel_frame_ctrl
// Purpose  : Frame sequencer in front of hw_accel. On start it flushes the
//            accelerator, aligns to the next source SOF, forwards exactly one
//            frame of pixels, then counts packed output words until the frame
//            is complete. Reports done, sticky errors and counts.
// Ports    : clk/rst                 clock, async active-high reset
//            start/abort             CPU command inputs
//            src_pixel/valid/sof     camera pixel stream
//            accel_rst               flush to hw_accel (also high during rst)
//            accel_pixel/valid       registered pixel stream to hw_accel
//            accel_out_valid         hw_accel packed-word strobe
//            busy/done               status
//            err_short/timeout/extra sticky error flags
//            in_count/out_count      per-frame pixel / word counts
// Revision : 1.0 - initial release
// ============================================================================
module hw_accel_frame_ctrl #(
  parameter int DATA_WIDTH    = 32,
  parameter int FRAME_WIDTH   = 540,
  parameter int FRAME_HEIGHT  = 540,
  parameter int OUT_WORDS     = 6912,
  parameter int DRAIN_TIMEOUT = 65535,
  localparam int TOTAL_PIX    = FRAME_WIDTH * FRAME_HEIGHT,
  localparam int IN_W         = $clog2(TOTAL_PIX + 1),
  localparam int OUT_W        = $clog2(OUT_WORDS + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [DATA_WIDTH-1:0] src_pixel,
  input  logic                  src_valid,
  input  logic                  src_sof,
  output logic                  accel_rst,
  output logic [DATA_WIDTH-1:0] accel_pixel,
  output logic                  accel_valid,
  input  logic                  accel_out_valid,
  output logic                  busy,
  output logic                  done,
  output logic                  err_short,
  output logic                  err_timeout,
  output logic                  err_extra,
  output logic [IN_W-1:0]       in_count,
  output logic [OUT_W-1:0]      out_count
);

  localparam int DRAIN_W = $clog2(DRAIN_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FLUSH    = 3'd1,
    S_WAIT_SOF = 3'd2,
    S_STREAM   = 3'd3,
    S_DRAIN    = 3'd4,
    S_DONE     = 3'd5
  } state_t;

  state_t                  state_q, state_d;
  logic                    flush_cnt_q, flush_cnt_d;
  logic [DRAIN_W-1:0]      drain_cnt_q, drain_cnt_d;
  logic [IN_W-1:0]         in_count_q, in_count_d;
  logic [OUT_W-1:0]        out_count_q, out_count_d;
  logic [DATA_WIDTH-1:0]   accel_pixel_q, accel_pixel_d;
  logic                    accel_valid_q, accel_valid_d;
  logic                    accel_rst_q, accel_rst_d;
  logic                    done_q, done_d;
  logic                    busy_q, busy_d;
  logic                    err_short_q, err_short_d;
  logic                    err_timeout_q, err_timeout_d;
  logic                    err_extra_q, err_extra_d;
  logic                    abort_take;

  always_comb begin
    state_d       = state_q;
    flush_cnt_d   = 1'b0;
    drain_cnt_d   = '0;
    in_count_d    = in_count_q;
    out_count_d   = out_count_q;
    accel_pixel_d = accel_pixel_q;
    accel_valid_d = 1'b0;
    err_short_d   = err_short_q;
    err_timeout_d = err_timeout_q;
    err_extra_d   = err_extra_q;
    abort_take    = abort && (state_q != S_IDLE);

    // Output-word accounting runs ahead of the state case so that a start in
    // IDLE can still clear the flags it may have just set.
    if (accel_out_valid) begin
      if ((state_q == S_STREAM) || (state_q == S_DRAIN) || (state_q == S_DONE)) begin
        if (out_count_q == OUT_W'(OUT_WORDS)) begin
          err_extra_d = 1'b1;
        end else begin
          out_count_d = out_count_q + OUT_W'(1);
        end
      end else begin
        err_extra_d = 1'b1;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          state_d       = S_FLUSH;
          err_short_d   = 1'b0;
          err_timeout_d = 1'b0;
          err_extra_d   = 1'b0;
          in_count_d    = '0;
          out_count_d   = '0;
        end
      end
      S_FLUSH: begin
        flush_cnt_d = 1'b1;
        if (flush_cnt_q) begin
          state_d = S_WAIT_SOF;
        end
      end
      S_WAIT_SOF: begin
        if (src_valid && src_sof) begin
          accel_valid_d = 1'b1;
          accel_pixel_d = src_pixel;
          in_count_d    = IN_W'(1);
          state_d       = (TOTAL_PIX == 1) ? S_DRAIN : S_STREAM;
        end
      end
      S_STREAM: begin
        if (src_valid && src_sof) begin
          // Early SOF: the frame was short; drop this pixel and realign.
          err_short_d = 1'b1;
          state_d     = S_FLUSH;
        end else if (src_valid) begin
          accel_valid_d = 1'b1;
          accel_pixel_d = src_pixel;
          in_count_d    = in_count_q + IN_W'(1);
          if (in_count_q == IN_W'(TOTAL_PIX - 1)) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        drain_cnt_d = drain_cnt_q + DRAIN_W'(1);
        if (out_count_q == OUT_W'(OUT_WORDS)) begin
          state_d = S_DONE;
        end else if (drain_cnt_q == DRAIN_W'(DRAIN_TIMEOUT - 1)) begin
          err_timeout_d = 1'b1;
          state_d       = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort wins over everything: no pixel goes out and the count stays put.
    if (abort_take) begin
      state_d       = S_IDLE;
      accel_valid_d = 1'b0;
      accel_pixel_d = accel_pixel_q;
      in_count_d    = in_count_q;
    end

    accel_rst_d = (state_d == S_FLUSH) || abort_take;
    done_d      = (state_d == S_DONE);
    busy_d      = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      flush_cnt_q   <= 1'b0;
      drain_cnt_q   <= '0;
      in_count_q    <= '0;
      out_count_q   <= '0;
      accel_pixel_q <= '0;
      accel_valid_q <= 1'b0;
      accel_rst_q   <= 1'b0;
      done_q        <= 1'b0;
      busy_q        <= 1'b0;
      err_short_q   <= 1'b0;
      err_timeout_q <= 1'b0;
      err_extra_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      flush_cnt_q   <= flush_cnt_d;
      drain_cnt_q   <= drain_cnt_d;
      in_count_q    <= in_count_d;
      out_count_q   <= out_count_d;
      accel_pixel_q <= accel_pixel_d;
      accel_valid_q <= accel_valid_d;
      accel_rst_q   <= accel_rst_d;
      done_q        <= done_d;
      busy_q        <= busy_d;
      err_short_q   <= err_short_d;
      err_timeout_q <= err_timeout_d;
      err_extra_q   <= err_extra_d;
    end
  end

  // The flush must reach hw_accel while rst is held, before any clock edge.
  assign accel_rst   = rst | accel_rst_q;
  assign accel_pixel = accel_pixel_q;
  assign accel_valid = accel_valid_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err_short   = err_short_q;
  assign err_timeout = err_timeout_q;
  assign err_extra   = err_extra_q;
  assign in_count    = in_count_q;
  assign out_count   = out_count_q;

endmodule
`default_nettype wire

// File: tb/tb_hw_accel_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_hw_accel_frame_ctrl
// Purpose  : Directed bench for hw_accel_frame_ctrl with W=H=4, OUT_WORDS=3,
//            DRAIN_TIMEOUT=20.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hw_accel_frame_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [31:0] src_pixel = '0;
  logic        src_valid = 1'b0;
  logic        src_sof = 1'b0;
  logic        accel_out_valid = 1'b0;
  logic        accel_rst;
  logic [31:0] accel_pixel;
  logic        accel_valid;
  logic        busy;
  logic        done;
  logic        err_short;
  logic        err_timeout;
  logic        err_extra;
  logic [4:0]  in_count;
  logic [1:0]  out_count;

  int          errors = 0;
  int          checks = 0;
  int          rst_cnt = 0;
  int          done_cnt = 0;
  logic [31:0] exp_q[$];

  hw_accel_frame_ctrl #(
    .DATA_WIDTH   (32),
    .FRAME_WIDTH  (4),
    .FRAME_HEIGHT (4),
    .OUT_WORDS    (3),
    .DRAIN_TIMEOUT(20)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .abort          (abort),
    .src_pixel      (src_pixel),
    .src_valid      (src_valid),
    .src_sof        (src_sof),
    .accel_rst      (accel_rst),
    .accel_pixel    (accel_pixel),
    .accel_valid    (accel_valid),
    .accel_out_valid(accel_out_valid),
    .busy           (busy),
    .done           (done),
    .err_short      (err_short),
    .err_timeout    (err_timeout),
    .err_extra      (err_extra),
    .in_count       (in_count),
    .out_count      (out_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Forwarded-pixel scoreboard plus pulse counters, sampled mid-cycle.
  always @(negedge clk) begin
    if (accel_rst) rst_cnt++;
    if (done) done_cnt++;
    if (accel_valid) begin
      chk("fwd_expected", (exp_q.size() > 0) ? 32'd1 : 32'd0, 32'd1);
      if (exp_q.size() > 0) chk("fwd_pixel", accel_pixel, exp_q.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_pix(input logic [31:0] pix, input logic sof, input logic fwd, input logic ov);
    src_pixel       = pix;
    src_valid       = 1'b1;
    src_sof         = sof;
    accel_out_valid = ov;
    if (fwd) exp_q.push_back(pix);
    tick();
    src_valid       = 1'b0;
    src_sof         = 1'b0;
    accel_out_valid = 1'b0;
  endtask

  task automatic start_cmd();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // n pixels starting at SOF; output words strobed on pixels 2..2+n_ov-1.
  task automatic frame(input int n, input int n_ov, input logic [31:0] base);
    for (int i = 0; i < n; i++) begin
      send_pix(base + 32'(i), (i == 0), 1'b1, (i >= 2) && (i < 2 + n_ov));
    end
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    chk("rst_accel_rst", accel_rst, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_valid", accel_valid, 0);
    chk("rst_pixel", accel_pixel, 0);
    chk("rst_in_count", in_count, 0);
    chk("rst_out_count", out_count, 0);
    chk("rst_errs", {err_short, err_timeout, err_extra}, 0);
    rst = 1'b0;
    tick();
    chk("post_rst_accel_rst", accel_rst, 0);

    // T1: junk during FLUSH and WAIT_SOF is dropped, one full frame completes
    rst_cnt = 0;
    done_cnt = 0;
    start_cmd();
    chk("t1_busy", busy, 1);
    chk("t1_flush_rst", accel_rst, 1);
    send_pix(32'hDEAD_0001, 1'b1, 1'b0, 1'b0);
    send_pix(32'hDEAD_0002, 1'b1, 1'b0, 1'b0);
    chk("t1_flush_len", rst_cnt, 2);
    chk("t1_wait_rst", accel_rst, 0);
    send_pix(32'hDEAD_0003, 1'b0, 1'b0, 1'b0);
    send_pix(32'hDEAD_0004, 1'b0, 1'b0, 1'b0);
    frame(16, 3, 32'h100);
    chk("t1_in_count", in_count, 16);
    chk("t1_out_count", out_count, 3);
    chk("t1_drain_done", done, 0);
    send_pix(32'hDEAD_0005, 1'b0, 1'b0, 1'b0);
    chk("t1_done", done, 1);
    tick();
    chk("t1_done_pulse", done, 0);
    chk("t1_busy_low", busy, 0);
    chk("t1_hold_in", in_count, 16);
    chk("t1_done_cnt", done_cnt, 1);
    chk("t1_queue_empty", exp_q.size(), 0);
    chk("t1_errs", {err_short, err_timeout, err_extra}, 0);

    // T2: short frame, retry on the next SOF
    start_cmd();
    tick();
    tick();
    frame(10, 0, 32'h200);
    chk("t2_in_count_short", in_count, 10);
    rst_cnt = 0;
    send_pix(32'h2FF, 1'b1, 1'b0, 1'b0);
    chk("t2_err_short", err_short, 1);
    chk("t2_flush_rst", accel_rst, 1);
    tick();
    chk("t2_flush_rst2", accel_rst, 1);
    tick();
    chk("t2_flush_end", accel_rst, 0);
    frame(16, 3, 32'h300);
    tick();
    chk("t2_done", done, 1);
    chk("t2_err_short_sticky", err_short, 1);
    tick();
    chk("t2_busy_low", busy, 0);
    chk("t2_in_count", in_count, 16);
    chk("t2_flush_len", rst_cnt, 2);
    chk("t2_queue_empty", exp_q.size(), 0);

    // T3: drain timeout with only two output words
    start_cmd();
    chk("t3_err_short_cleared", err_short, 0);
    tick();
    tick();
    frame(16, 2, 32'h400);
    for (int i = 0; i < 19; i++) tick();
    chk("t3_no_done_early", done, 0);
    chk("t3_no_timeout_early", err_timeout, 0);
    tick();
    chk("t3_done", done, 1);
    chk("t3_err_timeout", err_timeout, 1);
    chk("t3_out_count", out_count, 2);
    tick();
    chk("t3_busy_low", busy, 0);

    // T4: start+abort together stays idle; abort mid-stream; clean rerun
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    chk("t4_start_abort_idle", busy, 0);
    chk("t4_start_abort_norst", accel_rst, 0);
    start_cmd();
    tick();
    tick();
    frame(7, 0, 32'h500);
    chk("t4_in_count7", in_count, 7);
    done_cnt = 0;
    abort = 1'b1;
    send_pix(32'h5FF, 1'b0, 1'b0, 1'b0);
    abort = 1'b0;
    chk("t4_abort_idle", busy, 0);
    chk("t4_abort_rst", accel_rst, 1);
    chk("t4_abort_valid", accel_valid, 0);
    tick();
    chk("t4_abort_rst_1cyc", accel_rst, 0);
    start_cmd();
    tick();
    tick();
    frame(16, 3, 32'h600);
    tick();
    tick();
    chk("t4_done_cnt", done_cnt, 1);
    chk("t4_in_count", in_count, 16);
    chk("t4_out_count", out_count, 3);
    chk("t4_errs", {err_short, err_timeout, err_extra}, 0);
    accel_out_valid = 1'b1;
    tick();
    accel_out_valid = 1'b0;
    chk("t4_idle_extra", err_extra, 1);

    // T5: surplus output word and start during STREAM
    start_cmd();
    chk("t5_extra_cleared", err_extra, 0);
    tick();
    tick();
    rst_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      start = (i == 8);
      send_pix(32'h700 + 32'(i), (i == 0), 1'b1, (i >= 2) && (i < 6));
    end
    start = 1'b0;
    chk("t5_out_sat", out_count, 3);
    chk("t5_err_extra", err_extra, 1);
    chk("t5_in_count", in_count, 16);
    tick();
    chk("t5_done", done, 1);
    tick();
    chk("t5_busy_low", busy, 0);
    chk("t5_start_ignored", rst_cnt, 0);

    // T6: asynchronous reset mid-stream
    start_cmd();
    tick();
    tick();
    frame(5, 1, 32'h800);
    rst = 1'b1;
    #1;
    chk("t6_accel_rst", accel_rst, 1);
    chk("t6_busy", busy, 0);
    chk("t6_valid", accel_valid, 0);
    chk("t6_pixel", accel_pixel, 0);
    chk("t6_in_count", in_count, 0);
    chk("t6_out_count", out_count, 0);
    exp_q.delete();
    tick();
    rst = 1'b0;
    tick();
    chk("t6_release", accel_rst, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
